img_conv_sequencer: RTL

Command sequencer that sits in front of the image-convolution core's `op`/`en`/`busy` port.
- Host pushes a queue of opcodes with arguments, e.g. SET_NROWS, SET_NCOLS, SET_SIGMA, IMG_RX, CONV, IMG_TX.
- The sequencer issues them one at a time, waits for long operations to finish, and returns GET results on a response handshake.
- It removes all cycle-level knowledge of core busy behaviour from host logic.

---
 rtl/img_conv_pkg.sv | 43 ++++
 rtl/img_cmd_fifo.sv | 56 +++++
 rtl/img_conv_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/img_conv_pkg.sv
// rtl/img_conv_pkg.sv - shared opcode, command and sequencer-state types for the image-convolution core
package img_conv_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_SET_NROWS = 4'd1,
    OP_SET_NCOLS = 4'd2,
    OP_SET_SIGMA = 4'd3,
    OP_GET_NROWS = 4'd4,
    OP_GET_NCOLS = 4'd5,
    OP_GET_SIGMA = 4'd6,
    OP_IMG_RX    = 4'd7,
    OP_CONV      = 4'd8,
    OP_IMG_TX    = 4'd9
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE,
    S_RESP
  } seq_state_t;

  typedef struct packed {
    opcode_t    op;
    logic [7:0] arg;
  } cmd_t;

  function automatic logic is_long_op(input opcode_t op);
    return (op == OP_IMG_RX) || (op == OP_CONV) || (op == OP_IMG_TX);
  endfunction

  function automatic logic is_get_op(input opcode_t op);
    return (op == OP_GET_NROWS) || (op == OP_GET_NCOLS) || (op == OP_GET_SIGMA);
  endfunction

  function automatic logic is_set_op(input opcode_t op);
    return (op == OP_SET_NROWS) || (op == OP_SET_NCOLS) || (op == OP_SET_SIGMA);
  endfunction

endpackage

// File: rtl/img_cmd_fifo.sv
// rtl/img_cmd_fifo.sv - synchronous command FIFO of {opcode, arg} with flush
module img_cmd_fifo
  import img_conv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  cmd_t                     i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output cmd_t                     o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t           r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  // Flush wins over both ends so a same-cycle push or pop has no effect.
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

endmodule

// File: rtl/img_conv_sequencer.sv
// rtl/img_conv_sequencer.sv - queues host commands and issues them one at a time to the convolution core
module img_conv_sequencer
  import img_conv_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  opcode_t                  cmd_op,
  input  logic [7:0]               cmd_arg,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output opcode_t                  rsp_op,
  output logic [7:0]               rsp_data,
  output logic                     core_en,
  output opcode_t                  core_op,
  output logic [7:0]               core_din,
  input  logic [7:0]               core_dout,
  input  logic                     core_busy,
  input  logic                     flush,
  output logic                     idle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  seq_state_t     r_state;
  seq_state_t     w_next;
  cmd_t           w_head;
  cmd_t           w_din;
  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_take;
  logic           w_timeout;
  opcode_t        r_op;
  logic [7:0]     r_arg;
  logic [TW-1:0]  r_tcnt;
  logic           r_err;
  opcode_t        r_rsp_op;
  logic [7:0]     r_rsp_data;

  assign w_din     = '{op: cmd_op, arg: cmd_arg};
  assign cmd_ready = !w_full && !flush;
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty && !core_busy && !flush;
  // Unknown opcodes are popped but never reach the in-flight registers.
  assign w_take    = w_pop && (is_set_op(w_head.op) || is_get_op(w_head.op) || is_long_op(w_head.op));
  assign w_timeout = (r_state == S_WAIT_BUSY) && !core_busy && (r_tcnt == TW'(BUSY_TIMEOUT - 1));

  img_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .i_flush (flush),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_take) w_next = S_ISSUE;
      S_ISSUE: begin
        if (is_get_op(r_op))       w_next = S_CAPTURE;
        else if (is_long_op(r_op)) w_next = S_WAIT_BUSY;
        else                       w_next = S_IDLE;
      end
      S_WAIT_BUSY: begin
        if (core_busy)      w_next = S_WAIT_DONE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_WAIT_DONE: if (!core_busy) w_next = S_IDLE;
      S_CAPTURE:   w_next = S_RESP;
      S_RESP:      if (rsp_ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_arg      <= '0;
      r_tcnt     <= '0;
      r_err      <= 1'b0;
      r_rsp_op   <= OP_NOP;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_op  <= w_head.op;
        r_arg <= w_head.arg;
      end
      if (r_state == S_ISSUE)                      r_tcnt <= '0;
      else if (r_state == S_WAIT_BUSY && !core_busy) r_tcnt <= r_tcnt + TW'(1);
      // A timeout landing in a flush cycle is a fresh fault, so it stays visible.
      if (w_timeout)  r_err <= 1'b1;
      else if (flush) r_err <= 1'b0;
      if (r_state == S_CAPTURE) begin
        r_rsp_data <= core_dout;
        r_rsp_op   <= r_op;
      end
    end
  end

  assign core_en   = (r_state == S_ISSUE);
  assign core_op   = r_op;
  assign core_din  = r_arg;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_op    = r_rsp_op;
  assign rsp_data  = r_rsp_data;
  assign idle      = w_empty && (r_state == S_IDLE);
  assign err       = r_err;

endmodule
